// File: rtl/pacman_direction_ctrl.sv
// rtl/pacman_direction_ctrl.sv - debounced four-button direction command generator
// Buttons are synchronized, debounced and edge-detected; a two-state FSM holds the winning direction.
module pacman_direction_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8,
  parameter int HOLD_TICKS      = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btnL,
  input  logic btnU,
  input  logic btnR,
  input  logic btnD,
  input  logic consumed,
  output logic Left,
  output logic Up,
  output logic Right,
  output logic Down,
  output logic dirValid,
  output logic moveTick
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb;
  logic [3:0] deb_d;
  logic [3:0] press;
  logic [3:0] winner;

  state_t        state_q, state_n;
  logic [3:0]    dir_q, dir_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [TW-1:0] tick_cnt;
  logic          dir_valid_q;

  // Bit order throughout: 0 Left, 1 Up, 2 Right, 3 Down.
  assign raw = {btnD, btnR, btnU, btnL};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_d <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_deb
      logic [DW-1:0] dcnt;
      always_ff @(posedge clk) begin
        if (reset) begin
          deb[g] <= 1'b0;
          dcnt   <= '0;
        end else if (sync2[g] != deb[g]) begin
          if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb[g] <= sync2[g];
            dcnt   <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end else begin
          dcnt <= '0;
        end
      end
    end
  endgenerate

  assign press = deb & ~deb_d;

  always_comb begin
    winner = 4'b0000;
    if (press[0])      winner = 4'b0001;
    else if (press[1]) winner = 4'b0010;
    else if (press[2]) winner = 4'b0100;
    else if (press[3]) winner = 4'b1000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      moveTick <= 1'b0;
    end else begin
      moveTick <= (tick_cnt == TW'(TICK_DIV - 1));
      tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= '0;
      hold_q      <= '0;
      dir_valid_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      dir_q       <= dir_n;
      hold_q      <= hold_n;
      dir_valid_q <= |dir_n;
    end
  end

  // A new press outranks consumed and expiry; disable outranks everything.
  always_comb begin
    state_n = state_q;
    dir_n   = dir_q;
    hold_n  = hold_q;
    if (!enable) begin
      state_n = IDLE;
      dir_n   = '0;
      hold_n  = '0;
    end else if (|press) begin
      state_n = HOLD;
      dir_n   = winner;
      hold_n  = '0;
    end else if (state_q == HOLD) begin
      if (consumed) begin
        state_n = IDLE;
        dir_n   = '0;
        hold_n  = '0;
      end else if (moveTick) begin
        if (hold_q == HW'(HOLD_TICKS - 1)) begin
          state_n = IDLE;
          dir_n   = '0;
          hold_n  = '0;
        end else begin
          hold_n = hold_q + 1'b1;
        end
      end
    end
  end

  assign Left     = dir_q[0];
  assign Up       = dir_q[1];
  assign Right    = dir_q[2];
  assign Down     = dir_q[3];
  assign dirValid = dir_valid_q;

endmodule

// File: tb/tb_pacman_direction_ctrl.sv
// tb/tb_pacman_direction_ctrl.sv - scoreboard bench for pacman_direction_ctrl
// Stimulus queues expected output changes; a monitor pops them whenever the outputs change.
module tb_pacman_direction_ctrl;

  localparam int TICK = 8;

  logic clk = 1'b0;
  logic reset, enable, btnL, btnU, btnR, btnD, consumed;
  logic Left, Up, Right, Down, dirValid, moveTick;

  pacman_direction_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8), .HOLD_TICKS(3)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .btnL(btnL), .btnU(btnU), .btnR(btnR), .btnD(btnD),
    .consumed(consumed),
    .Left(Left), .Up(Up), .Right(Right), .Down(Down),
    .dirValid(dirValid), .moveTick(moveTick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   last_rst = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;
  logic [4:0] prev_outs = 5'b0;
  logic [4:0] outs;
  int   R;

  assign outs = {Left, Up, Right, Down, dirValid};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) last_rst <= cyc + 1;
  end

  // Outputs vector is {Left,Up,Right,Down,dirValid}.
  always @(negedge clk) begin
    if (mon_on) begin
      logic exp_tick;
      exp_tick = (cyc > last_rst) && (((cyc - last_rst) % TICK) == 0);
      n_assert++;
      if (moveTick !== exp_tick) begin
        n_fail++;
        $display("FAIL movetick cyc=%0d actual=%b required=%b", cyc, moveTick, exp_tick);
      end
      if (outs !== prev_outs) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d actual=%b required=%b", cyc, outs, prev_outs);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.v !== outs || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL out_change actual=%b@%0d required=%b@%0d", outs, cyc, e.v, e.cyc);
          end
        end
        prev_outs = outs;
      end
    end
  end

  task automatic push(input int c, input logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    R = cyc;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; consumed = 1'b0;
    btnL = 1'b0; btnU = 1'b0; btnR = 1'b0; btnD = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if (outs !== 5'b0 || moveTick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state actual=%b,%b required=00000,0", outs, moveTick);
    end
    reset = 1'b0;
    R = cyc;
    mon_on = 1'b1;

    // Held Left: asserted after edge R+8, expires on the third tick (seen at R+25), no re-press.
    wait_until(R + 1); btnL = 1'b1;
    push(R + 8, 5'b10001);
    push(R + 25, 5'b00000);
    wait_until(R + 45); btnL = 1'b0;
    wait_until(R + 60);

    // Three-cycle glitch never reaches the debounced level.
    do_reset();
    wait_until(R + 1); btnL = 1'b1;
    wait_until(R + 4); btnL = 1'b0;
    wait_until(R + 25);

    // Up and Right together: Up wins; consumed clears.
    do_reset();
    wait_until(R + 1); btnU = 1'b1; btnR = 1'b1;
    push(R + 8, 5'b01001);
    wait_until(R + 10); consumed = 1'b1;
    push(R + 11, 5'b00000);
    wait_until(R + 11); consumed = 1'b0;
    wait_until(R + 14); btnU = 1'b0; btnR = 1'b0;
    wait_until(R + 30);

    // Down held, Right press coincides with consumed: Right replaces Down.
    do_reset();
    wait_until(R + 1); btnD = 1'b1;
    push(R + 8, 5'b00011);
    wait_until(R + 10); btnR = 1'b1;
    wait_until(R + 16); consumed = 1'b1;
    push(R + 17, 5'b00101);
    push(R + 41, 5'b00000);
    wait_until(R + 17); consumed = 1'b0;
    wait_until(R + 45); btnD = 1'b0; btnR = 1'b0;
    wait_until(R + 60);

    // Reset pulse in HOLD clears outputs and restarts the tick phase.
    do_reset();
    wait_until(R + 1); btnL = 1'b1;
    push(R + 8, 5'b10001);
    wait_until(R + 12); btnL = 1'b0; reset = 1'b1;
    push(R + 13, 5'b00000);
    wait_until(R + 13); reset = 1'b0;
    wait_until(R + 45);

    // Press while disabled is discarded and not replayed on re-enable.
    do_reset();
    wait_until(R + 1); enable = 1'b0; btnU = 1'b1;
    wait_until(R + 12); enable = 1'b1;
    wait_until(R + 14); btnU = 1'b0;
    wait_until(R + 30);

    // Button already held when reset releases still produces one press.
    @(negedge clk);
    reset = 1'b1; btnR = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    R = cyc;
    push(R + 7, 5'b00101);
    wait_until(R + 9); consumed = 1'b1;
    push(R + 10, 5'b00000);
    wait_until(R + 10); consumed = 1'b0;
    wait_until(R + 14); btnR = 1'b0;
    wait_until(R + 30);

    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_changes actual=%0d pending required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
